cpu_ctrl: RTL and testbench

Control unit for the 16-bit multi-cycle CPU: fetches instruction words from memory, decodes them, and drives the 12-bit control word, `ops` field and `pc` into the datapath. It also drives the memory write strobe. It sits opposite the datapath and consumes the datapath's `psw` flags for conditional branches. One instruction completes every 2 cycles, except shift-multiple, which takes 2+n cycles.

---
 rtl/cpu_pkg.sv | 104 ++++++++++
 rtl/cpu_ctrl_dec.sv | 46 ++++
 rtl/cpu_ctrl.sv | 133 +++++++++++++
 tb/tb_cpu_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Opcodes, ALU function codes, FSM states and decode types shared
//            by the cpu_ctrl control unit.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam logic [6:0] c_OP_MOVA = 7'b0000000;
    localparam logic [6:0] c_OP_INC  = 7'b0000001;
    localparam logic [6:0] c_OP_ADD  = 7'b0000010;
    localparam logic [6:0] c_OP_SUB  = 7'b0000101;
    localparam logic [6:0] c_OP_DEC  = 7'b0000110;
    localparam logic [6:0] c_OP_AND  = 7'b0001000;
    localparam logic [6:0] c_OP_OR   = 7'b0001001;
    localparam logic [6:0] c_OP_XOR  = 7'b0001010;
    localparam logic [6:0] c_OP_NOT  = 7'b0001011;
    localparam logic [6:0] c_OP_MOVB = 7'b0001100;
    localparam logic [6:0] c_OP_SHR  = 7'b0001101;
    localparam logic [6:0] c_OP_SHL  = 7'b0001110;
    localparam logic [6:0] c_OP_LD   = 7'b0010000;
    localparam logic [6:0] c_OP_ST   = 7'b0100000;
    localparam logic [6:0] c_OP_LDI  = 7'b1001100;
    localparam logic [6:0] c_OP_ADI  = 7'b1000010;
    localparam logic [6:0] c_OP_SRM  = 7'b0001111;
    localparam logic [6:0] c_OP_SLM  = 7'b0010001;
    localparam logic [6:0] c_OP_BRZ  = 7'b1100000;
    localparam logic [6:0] c_OP_BRN  = 7'b1100001;
    localparam logic [6:0] c_OP_JMP  = 7'b1110000;
    localparam logic [6:0] c_OP_HALT = 7'b1111111;

    localparam logic [4:0] c_FS_MOVA = 5'b00000;
    localparam logic [4:0] c_FS_INC  = 5'b00001;
    localparam logic [4:0] c_FS_ADD  = 5'b00010;
    localparam logic [4:0] c_FS_SUB  = 5'b00101;
    localparam logic [4:0] c_FS_DEC  = 5'b00110;
    localparam logic [4:0] c_FS_AND  = 5'b01000;
    localparam logic [4:0] c_FS_OR   = 5'b01001;
    localparam logic [4:0] c_FS_XOR  = 5'b01010;
    localparam logic [4:0] c_FS_NOT  = 5'b01011;
    localparam logic [4:0] c_FS_MOVB = 5'b01100;
    localparam logic [4:0] c_FS_SHR  = 5'b10100;
    localparam logic [4:0] c_FS_SHL  = 5'b11000;

    localparam int c_PSW_Z = 0;
    localparam int c_PSW_N = 1;
    localparam int c_PSW_C = 2;
    localparam int c_PSW_V = 3;

    typedef enum logic [1:0] {
        ST_INF  = 2'd0,
        ST_EX0  = 2'd1,
        ST_EX1  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        CL_ALU  = 4'd0,
        CL_LD   = 4'd1,
        CL_ST   = 4'd2,
        CL_BRZ  = 4'd3,
        CL_BRN  = 4'd4,
        CL_JMP  = 4'd5,
        CL_SRM  = 4'd6,
        CL_SLM  = 4'd7,
        CL_HALT = 4'd8,
        CL_NOP  = 4'd9
    } iclass_t;

    typedef struct packed {
        logic       mb;
        logic [4:0] fs;
        logic       md;
        logic       rw;
        logic       mw;
        iclass_t    cls;
    } dec_t;

    function automatic dec_t dec_alu(input logic [4:0] fs, input logic mb);
        dec_t d;
        d.mb  = mb;
        d.fs  = fs;
        d.md  = 1'b0;
        d.rw  = 1'b1;
        d.mw  = 1'b0;
        d.cls = CL_ALU;
        return d;
    endfunction

    function automatic dec_t dec_ctl(input iclass_t cls, input logic md,
                                     input logic rw, input logic mw);
        dec_t d;
        d.mb  = 1'b0;
        d.fs  = c_FS_MOVA;
        d.md  = md;
        d.rw  = rw;
        d.mw  = mw;
        d.cls = cls;
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_ctrl_dec.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_dec
// Brief    : Combinational opcode decoder producing the execute-cycle control
//            fields and the instruction class used by the sequencer.
// Revision : 1.0
// ============================================================================
module cpu_ctrl_dec
    import cpu_pkg::*;
(
    input  logic [6:0] i_op,
    output dec_t       o_dec
);

    always_comb begin
        o_dec = dec_ctl(CL_NOP, 1'b0, 1'b0, 1'b0);
        case (i_op)
            c_OP_MOVA: o_dec = dec_alu(c_FS_MOVA, 1'b0);
            c_OP_INC:  o_dec = dec_alu(c_FS_INC,  1'b0);
            c_OP_ADD:  o_dec = dec_alu(c_FS_ADD,  1'b0);
            c_OP_SUB:  o_dec = dec_alu(c_FS_SUB,  1'b0);
            c_OP_DEC:  o_dec = dec_alu(c_FS_DEC,  1'b0);
            c_OP_AND:  o_dec = dec_alu(c_FS_AND,  1'b0);
            c_OP_OR:   o_dec = dec_alu(c_FS_OR,   1'b0);
            c_OP_XOR:  o_dec = dec_alu(c_FS_XOR,  1'b0);
            c_OP_NOT:  o_dec = dec_alu(c_FS_NOT,  1'b0);
            c_OP_MOVB: o_dec = dec_alu(c_FS_MOVB, 1'b0);
            c_OP_SHR:  o_dec = dec_alu(c_FS_SHR,  1'b0);
            c_OP_SHL:  o_dec = dec_alu(c_FS_SHL,  1'b0);
            // Immediate forms reuse their register-form ALU code with imm3 on busB
            c_OP_LDI:  o_dec = dec_alu(c_FS_MOVB, 1'b1);
            c_OP_ADI:  o_dec = dec_alu(c_FS_ADD,  1'b1);
            c_OP_LD:   o_dec = dec_ctl(CL_LD,   1'b1, 1'b1, 1'b0);
            c_OP_ST:   o_dec = dec_ctl(CL_ST,   1'b0, 1'b0, 1'b1);
            c_OP_SRM:  o_dec = dec_ctl(CL_SRM,  1'b0, 1'b1, 1'b0);
            c_OP_SLM:  o_dec = dec_ctl(CL_SLM,  1'b0, 1'b1, 1'b0);
            c_OP_BRZ:  o_dec = dec_ctl(CL_BRZ,  1'b0, 1'b0, 1'b0);
            c_OP_BRN:  o_dec = dec_ctl(CL_BRN,  1'b0, 1'b0, 1'b0);
            c_OP_JMP:  o_dec = dec_ctl(CL_JMP,  1'b0, 1'b0, 1'b0);
            c_OP_HALT: o_dec = dec_ctl(CL_HALT, 1'b0, 1'b0, 1'b0);
            default:   o_dec = dec_ctl(CL_NOP,  1'b0, 1'b0, 1'b0);
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl
// Brief    : Multi-cycle CPU control unit: fetch/execute sequencer, program
//            counter, instruction register and shift-multiple counter.
// Revision : 1.0
// ============================================================================
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int BW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [BW-1:0] din,
    input  logic [3:0]    psw,
    output logic [12:1]   mode,
    output logic [8:0]    ops,
    output logic [BW-1:0] pc,
    output logic          mw,
    output logic          halted
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [BW-1:0] r_pc;
    logic [BW-1:0] w_pc_nxt;
    logic [BW-1:0] r_ir;
    logic [BW-1:0] w_ir_nxt;
    logic [2:0]    r_cnt;
    logic [2:0]    w_cnt_nxt;
    dec_t          w_dec;
    logic [BW-1:0] w_off;
    logic [4:0]    w_shift_fs;
    logic          w_unused_psw;

    cpu_ctrl_dec u_dec (
        .i_op  (r_ir[15:9]),
        .o_dec (w_dec)
    );

    // Branch offset is {DR, SB} so SA stays free; relative to the incremented pc
    assign w_off        = {{(BW-6){r_ir[8]}}, r_ir[8:6], r_ir[2:0]};
    assign w_shift_fs   = (w_dec.cls == CL_SLM) ? c_FS_SHL : c_FS_SHR;
    assign w_unused_psw = ^psw[c_PSW_V:c_PSW_C];
    assign pc           = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INF;
            r_pc    <= '0;
            r_ir    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_cnt_nxt   = r_cnt;
        mode        = 12'h000;
        ops         = r_ir[8:0];
        mw          = 1'b0;
        halted      = 1'b0;

        case (r_state)
            ST_INF: begin
                mode        = 12'h001;
                w_ir_nxt    = din;
                w_pc_nxt    = r_pc + 1'b1;
                w_state_nxt = ST_EX0;
            end

            ST_EX0: begin
                mode        = {3'b000, w_dec.mb, w_dec.fs, w_dec.md, w_dec.rw, 1'b0};
                mw          = w_dec.mw;
                w_state_nxt = ST_INF;
                case (w_dec.cls)
                    CL_BRZ: begin
                        if (psw[c_PSW_Z]) begin
                            w_pc_nxt = r_pc + w_off;
                        end
                    end
                    CL_BRN: begin
                        if (psw[c_PSW_N]) begin
                            w_pc_nxt = r_pc + w_off;
                        end
                    end
                    CL_JMP: begin
                        w_pc_nxt = r_pc + w_off;
                    end
                    CL_SRM, CL_SLM: begin
                        w_cnt_nxt = r_ir[2:0];
                        if (r_ir[2:0] != 3'd0) begin
                            w_state_nxt = ST_EX1;
                        end
                    end
                    CL_HALT: begin
                        w_state_nxt = ST_HALT;
                    end
                    default: begin
                    end
                endcase
            end

            // Shift loop operates in place on R[DR], hence SA is overridden by DR
            ST_EX1: begin
                mode      = {3'b000, 1'b0, w_shift_fs, 1'b0, 1'b1, 1'b0};
                ops       = {r_ir[8:6], r_ir[8:6], r_ir[2:0]};
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == 3'd1) begin
                    w_state_nxt = ST_INF;
                end
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: begin
                w_state_nxt = ST_INF;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_ctrl
// Brief    : Scoreboard bench for cpu_ctrl; an instruction-level model predicts
//            the per-cycle control outputs from memory contents and psw.
// Revision : 1.0
// ============================================================================
module tb_cpu_ctrl;

    localparam logic [6:0] c_MOVA = 7'b0000000, c_INC = 7'b0000001, c_ADD = 7'b0000010;
    localparam logic [6:0] c_SUB  = 7'b0000101, c_DEC = 7'b0000110, c_AND = 7'b0001000;
    localparam logic [6:0] c_OR   = 7'b0001001, c_XOR = 7'b0001010, c_NOT = 7'b0001011;
    localparam logic [6:0] c_MOVB = 7'b0001100, c_SHR = 7'b0001101, c_SHL = 7'b0001110;
    localparam logic [6:0] c_LD   = 7'b0010000, c_ST  = 7'b0100000, c_LDI = 7'b1001100;
    localparam logic [6:0] c_ADI  = 7'b1000010, c_SRM = 7'b0001111, c_SLM = 7'b0010001;
    localparam logic [6:0] c_BRZ  = 7'b1100000, c_BRN = 7'b1100001, c_JMP = 7'b1110000;
    localparam logic [6:0] c_HALT = 7'b1111111;

    typedef struct packed {
        logic [11:0] mode;
        logic [11:0] mask;
        logic [8:0]  ops;
        logic [15:0] pc;
        logic        mw;
        logic        halted;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic [3:0]  psw;
    logic [11:0] mode;
    logic [8:0]  ops;
    logic [15:0] pc;
    logic        mw;
    logic        halted;

    logic [15:0] mem [0:65535];
    logic [3:0]  psw_seq [0:1023];
    exp_t        sb [$];
    exp_t        m_e;
    logic        chk_en;
    int          n_tests;
    int          n_fail;

    assign din = mem[pc];

    cpu_ctrl #(.BW(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .psw    (psw),
        .mode   (mode),
        .ops    (ops),
        .pc     (pc),
        .mw     (mw),
        .halted (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [11:0] md, input logic [11:0] mk_mask,
                                input logic [8:0] o, input logic [15:0] p,
                                input logic w, input logic h);
        exp_t e;
        e.mode = md; e.mask = mk_mask; e.ops = o; e.pc = p; e.mw = w; e.halted = h;
        return e;
    endfunction

    // kind: 0 ALU, 1 LD, 2 ST, 3 BRZ, 4 BRN, 5 JMP, 6 SRM, 7 SLM, 8 HALT, 9 NOP
    function automatic void classify(input logic [6:0] op, output int kind,
                                     output logic [4:0] fs, output logic mb);
        kind = 0; fs = 5'b00000; mb = 1'b0;
        case (op)
            c_MOVA: fs = 5'b00000;
            c_INC:  fs = 5'b00001;
            c_ADD:  fs = 5'b00010;
            c_SUB:  fs = 5'b00101;
            c_DEC:  fs = 5'b00110;
            c_AND:  fs = 5'b01000;
            c_OR:   fs = 5'b01001;
            c_XOR:  fs = 5'b01010;
            c_NOT:  fs = 5'b01011;
            c_MOVB: fs = 5'b01100;
            c_SHR:  fs = 5'b10100;
            c_SHL:  fs = 5'b11000;
            c_LDI:  begin fs = 5'b01100; mb = 1'b1; end
            c_ADI:  begin fs = 5'b00010; mb = 1'b1; end
            c_LD:   kind = 1;
            c_ST:   kind = 2;
            c_BRZ:  kind = 3;
            c_BRN:  kind = 4;
            c_JMP:  kind = 5;
            c_SRM:  kind = 6;
            c_SLM:  kind = 7;
            c_HALT: kind = 8;
            default: kind = 9;
        endcase
    endfunction

    // Expected outputs: one reset cycle, then ncyc cycles of program execution
    function automatic void build_trace(input int ncyc);
        exp_t        q [$];
        logic [15:0] p, ir, off;
        logic [4:0]  fs;
        logic        mb, take;
        int          kind, te;
        p = 16'h0000; ir = 16'h0000;
        q.push_back(mk(12'h001, 12'hFFF, 9'h000, 16'h0000, 1'b0, 1'b0));
        while (q.size() < ncyc + 1) begin
            if (q.size() > 1 && q[q.size()-1].halted) begin
                q.push_back(mk(12'h000, 12'hFFF, ir[8:0], p, 1'b0, 1'b1));
            end else begin
                q.push_back(mk(12'h001, 12'hFFF, ir[8:0], p, 1'b0, 1'b0));
                ir = mem[p];
                p  = p + 16'd1;
                classify(ir[15:9], kind, fs, mb);
                off = {{10{ir[8]}}, ir[8:6], ir[2:0]};
                te  = q.size() - 1;
                case (kind)
                    0: q.push_back(mk({3'b000, mb, fs, 3'b010}, 12'hFFF, ir[8:0], p, 1'b0, 1'b0));
                    1: q.push_back(mk(12'b000_0_00000_110, 12'b111_0_00000_111, ir[8:0], p, 1'b0, 1'b0));
                    2: q.push_back(mk(12'b000_0_00000_000, 12'b111_0_00000_011, ir[8:0], p, 1'b1, 1'b0));
                    3, 4, 5: begin
                        take = (kind == 5) || (kind == 3 && psw_seq[te][0]) ||
                               (kind == 4 && psw_seq[te][1]);
                        q.push_back(mk(12'h000, 12'b111_0_00000_010, ir[8:0], p, 1'b0, 1'b0));
                        if (take) p = p + off;
                    end
                    6, 7: begin
                        q.push_back(mk(12'b000_0_00000_010, 12'b111_0_11111_110, ir[8:0], p, 1'b0, 1'b0));
                        for (int i = 0; i < int'(ir[2:0]); i++) begin
                            q.push_back(mk({4'b0000, (kind == 6) ? 5'b10100 : 5'b11000, 3'b010},
                                           12'b111_0_11111_110, {ir[8:6], ir[8:6], ir[2:0]},
                                           p, 1'b0, 1'b0));
                        end
                    end
                    8: begin
                        q.push_back(mk(12'h000, 12'b111_0_00000_010, ir[8:0], p, 1'b0, 1'b0));
                        q.push_back(mk(12'h000, 12'hFFF, ir[8:0], p, 1'b0, 1'b1));
                    end
                    default: q.push_back(mk(12'h000, 12'b111_0_00000_010, ir[8:0], p, 1'b0, 1'b0));
                endcase
            end
        end
        q = q[0:ncyc];
        foreach (q[i]) sb.push_back(q[i]);
    endfunction

    function automatic logic [15:0] enc(input logic [6:0] op, input logic [2:0] dr,
                                        input logic [2:0] sa, input logic [2:0] sbf);
        return {op, dr, sa, sbf};
    endfunction

    function automatic logic [15:0] br(input logic [6:0] op, input int off);
        logic [31:0] o;
        o = off;
        return {op, o[5:3], 3'b000, o[2:0]};
    endfunction

    function automatic logic [15:0] rnd_instr();
        logic [6:0] op;
        case ($urandom_range(0, 22))
            0: op = c_MOVA;   1: op = c_INC;   2: op = c_ADD;   3: op = c_SUB;
            4: op = c_DEC;    5: op = c_AND;   6: op = c_OR;    7: op = c_XOR;
            8: op = c_NOT;    9: op = c_MOVB;  10: op = c_SHR;  11: op = c_SHL;
            12: op = c_LD;    13: op = c_ST;   14: op = c_LDI;  15: op = c_ADI;
            16: op = c_SRM;   17: op = c_SLM;  18: op = c_BRZ;  19: op = c_BRN;
            20: op = c_JMP;
            21: op = ($urandom_range(0, 9) == 0) ? c_HALT : c_ADD;
            default: op = 7'($urandom);
        endcase
        return {op, 9'($urandom)};
    endfunction

    task automatic fill_mem(input bit rnd);
        for (int a = 0; a < 65536; a++) mem[a] = rnd ? rnd_instr() : 16'h0000;
    endtask

    // zuntil < 0: random psw; otherwise Z for the first zuntil cycles, then N
    task automatic run(input int ncyc, input int zuntil);
        for (int t = 0; t < 1024; t++) begin
            if (zuntil < 0) psw_seq[t] = 4'($urandom);
            else            psw_seq[t] = (t < zuntil) ? 4'b0001 : 4'b0010;
        end
        build_trace(ncyc);
        @(posedge clk); #1; rst = 1'b1; chk_en = 1'b0;
        @(posedge clk); #1; chk_en = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        for (int t = 0; t < ncyc; t++) begin
            psw = psw_seq[t];
            @(posedge clk); #1;
        end
        chk_en = 1'b0;
        chk("sb_drain", sb.size(), 0);
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                m_e = sb.pop_front();
                chk("mode",   mode & m_e.mask, m_e.mode & m_e.mask);
                chk("ops",    ops,    m_e.ops);
                chk("pc",     pc,     m_e.pc);
                chk("mw",     mw,     m_e.mw);
                chk("halted", halted, m_e.halted);
            end
        end
    end

    initial begin
        n_tests = 0; n_fail = 0; chk_en = 1'b0; rst = 1'b1; psw = 4'h0;

        fill_mem(1'b0);
        mem[0]  = enc(c_ADD,  3'd3, 3'd1, 3'd2);
        mem[1]  = enc(c_LDI,  3'd1, 3'd0, 3'd5);
        mem[2]  = enc(c_ST,   3'd0, 3'd4, 3'd5);
        mem[3]  = enc(c_LD,   3'd2, 3'd4, 3'd0);
        mem[4]  = br(c_BRZ, -2);
        mem[5]  = enc(c_SRM,  3'd2, 3'd2, 3'd3);
        mem[6]  = enc(c_SRM,  3'd1, 3'd1, 3'd0);
        mem[7]  = enc(c_SLM,  3'd3, 3'd3, 3'd5);
        mem[8]  = enc(c_ADI,  3'd4, 3'd4, 3'd7);
        mem[9]  = enc(7'b0111111, 3'd1, 3'd2, 3'd3);
        mem[10] = br(c_BRN, 1);
        mem[11] = enc(c_HALT, 3'd0, 3'd0, 3'd0);
        mem[12] = enc(c_XOR,  3'd5, 3'd6, 3'd7);
        mem[13] = enc(c_HALT, 3'd0, 3'd0, 3'd0);
        run(90, 20);

        fill_mem(1'b0);
        mem[0]      = br(c_JMP, -3);
        mem[16'hFFFE] = br(c_JMP, 2);
        mem[1]      = br(c_JMP, -3);
        mem[16'hFFFF] = enc(c_INC, 3'd1, 3'd1, 3'd0);
        run(30, -1);

        fill_mem(1'b0);
        mem[0] = enc(c_SRM, 3'd1, 3'd1, 3'd7);
        mem[1] = enc(c_SLM, 3'd6, 3'd0, 3'd2);
        run(4, -1);
        run(16, -1);

        for (int r = 0; r < 3; r++) begin
            fill_mem(1'b1);
            run(250, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
